id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I pipeline.
- Applies the forwarding selects (ForwardA/ForwardB, generated in decode from rs1_addr_D/rs2_addr_D) to the register-file read data, then latches the decode bundle into EX.
- Detects load-use hazards, inserts bubbles, holds on a busy EX unit, and squashes on flush.
- Produces stall_F/stall_D for the front end and counts inserted bubbles.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- valid_D  in  1  decode slot holds a real instruction.
- pc_D  in  XLEN  decode PC.
- rs1_data_D, rs2_data_D  in  XLEN  register-file read data.
- imm_D  in  XLEN  decoded immediate.
- rs1_addr_D, rs2_addr_D, rd_addr_D  in  5  register indices.
- rs1_used_D, rs2_used_D  in  1  instruction actually reads rs1/rs2.
- rd_wren_D, mem_rden_D, mem_wren_D, br_D  in  1  control bits.
- alu_op_D  in  4  ALU operation.
- ForwardA, ForwardB  in  2  forwarding selects (10=M, 01=W, 00=RF).
- alu_data_M  in  XLEN  MEM-stage ALU result.
- wb_data_W  in  XLEN  WB-stage write data.
- rd_addr_M  in  5  MEM-stage destination register.
- mem_rden_M  in  1  MEM-stage instruction is a load.
- ex_busy  in  1  multi-cycle EX unit not ready to accept.
- flush_E  in  1  squash the EX slot (taken branch/jump resolved).
- stall_F, stall_D  out  1  hold PC and the IF/ID register.
- valid_E, pc_E, rs1_val_E, rs2_val_E, imm_E, rs1_addr_E, rs2_addr_E, rd_addr_E, rd_wren_E, mem_rden_E, mem_wren_E, br_E, alu_op_E  out  (widths as in D)  registered EX bundle.
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset: i_clk single clock; i_reset asynchronous, active-high. While asserted, every registered output is 0 and bubble_cnt=0. Asserting reset mid-stall discards the stall.
- Operand select (combinational):
  - Fwd=10 selects alu_data_M.
  - Fwd=01 selects wb_data_W.
  - Fwd=00 and the reserved 11 select the RF data.
  - rs1_val_E/rs2_val_E latch the selected value.
- Load-use hazard (lu), evaluated per source as used && addr!=0 && valid_D && either:
  - mem_rden_E && valid_E && rd_addr_E==addr, or
  - mem_rden_M && rd_addr_M==addr.
  - A load therefore costs exactly 2 bubbles; the value is then forwarded from W.
- stall_D = stall_F = valid_D && (lu || ex_busy) && !flush_E.
- Register update priority at each clock edge:
  1. flush_E: bubble into E (valid_E, rd_wren_E, mem_rden_E, mem_wren_E, br_E = 0; data fields don't-care, drive 0).
  2. ex_busy: hold all E fields unchanged.
  3. lu: bubble into E, bubble_cnt += 1.
  4. Otherwise: load the D bundle, with valid_E=valid_D.
- A bubble never asserts any write/load/store/branch control bit.
- rd_addr_D==0 with rd_wren_D=1 is latched as-is; x0 suppression is the register file's job.
- bubble_cnt saturates at all-ones and does not wrap.
- Latency: 1 cycle from D inputs to E outputs. There is no combinational path from E outputs to stall except through registered valid_E/mem_rden_E/rd_addr_E.
- flush_E and lu in the same cycle: flush wins, no count, stall not asserted. The front end is redirected anyway.

Test Plan:
1. Reset mid-operation: assert i_reset with the E bundle loaded and a stall active → all outputs 0 immediately (async), stall_F=0, bubble_cnt=0.
2. Forwarding select: ForwardA=10, alu_data_M=0x1234, rs1_data_D=0xFFFF → next edge rs1_val_E=0x1234. ForwardB=01, wb_data_W=0xABCD → rs2_val_E=0xABCD. ForwardA=11 → RF data.
3. Load-use: lw x5 in E, add x6,x5,x1 in D → stall_D high for 2 cycles, 2 bubbles (valid_E=0), bubble_cnt=2. On the 3rd cycle the add enters E with W-forwarded x5.
4. Load to x0: lw x0 then use x0 → no stall, bubble_cnt unchanged.
5. Busy hold: ex_busy=1 for 3 cycles with a valid instruction in D → E fields frozen, stall_D=1, no count. The instruction advances on the cycle after ex_busy drops.
6. Flush priority: flush_E=1 together with lu and ex_busy → valid_E=0 and all control bits 0 next cycle, stall_D=0, bubble_cnt unchanged. Saturation check: preload CNT_W=4 and force 20 bubbles → bubble_cnt=15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I pipeline.
// Applies the decode-generated forwarding selects to the register-file read
// data, then latches the decode bundle into EX. Detects load-use hazards and
// inserts bubbles, holds while the EX unit is busy, squashes on flush, and
// counts the load-use bubbles it inserts.
//
// Ports:
//   i_clk, i_reset             clock (rising edge), async active-high reset
//   valid_D .. alu_op_D        decode bundle
//   ForwardA, ForwardB         operand selects (10=M, 01=W, 00/11=RF)
//   alu_data_M, wb_data_W      forwarding sources
//   rd_addr_M, mem_rden_M      MEM-stage destination / load flag
//   ex_busy, flush_E           EX hold and EX squash
//   stall_F, stall_D           combinational front-end hold
//   valid_E .. alu_op_E        registered EX bundle
//   bubble_cnt                 saturating load-use bubble counter
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             valid_D,
  input  logic [XLEN-1:0]  pc_D,
  input  logic [XLEN-1:0]  rs1_data_D,
  input  logic [XLEN-1:0]  rs2_data_D,
  input  logic [XLEN-1:0]  imm_D,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rd_addr_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic             rd_wren_D,
  input  logic             mem_rden_D,
  input  logic             mem_wren_D,
  input  logic             br_D,
  input  logic [3:0]       alu_op_D,
  input  logic [1:0]       ForwardA,
  input  logic [1:0]       ForwardB,
  input  logic [XLEN-1:0]  alu_data_M,
  input  logic [XLEN-1:0]  wb_data_W,
  input  logic [4:0]       rd_addr_M,
  input  logic             mem_rden_M,
  input  logic             ex_busy,
  input  logic             flush_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             valid_E,
  output logic [XLEN-1:0]  pc_E,
  output logic [XLEN-1:0]  rs1_val_E,
  output logic [XLEN-1:0]  rs2_val_E,
  output logic [XLEN-1:0]  imm_E,
  output logic [4:0]       rs1_addr_E,
  output logic [4:0]       rs2_addr_E,
  output logic [4:0]       rd_addr_E,
  output logic             rd_wren_E,
  output logic             mem_rden_E,
  output logic             mem_wren_E,
  output logic             br_E,
  output logic [3:0]       alu_op_E,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 4;
  localparam logic [1:0]  FWD_M = 2'b10;
  localparam logic [1:0]  FWD_W = 2'b01;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_W-1:0]  rs1_addr;
    logic [REG_W-1:0]  rs2_addr;
    logic [REG_W-1:0]  rd_addr;
    logic              rd_wren;
    logic              mem_rden;
    logic              mem_wren;
    logic              br;
    logic [OP_W-1:0]   alu_op;
  } ex_bundle_t;

  ex_bundle_t       e_q, e_d, d_bundle_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rs1_sel_c, rs2_sel_c;
  logic             lu_rs1_c, lu_rs2_c, lu_c;

  // Operand mux; the reserved 11 encoding falls back to register-file data.
  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] m,
                                              input logic [XLEN-1:0] w);
    logic [XLEN-1:0] r;
    case (sel)
      FWD_M:   r = m;
      FWD_W:   r = w;
      default: r = rf;
    endcase
    return r;
  endfunction

  // Per-source load-use check against a load in E (registered) or in M.
  function automatic logic lu_src(input logic             used,
                                  input logic [REG_W-1:0] addr,
                                  input logic             v_d,
                                  input logic             v_e,
                                  input logic             ld_e,
                                  input logic [REG_W-1:0] rd_e,
                                  input logic             ld_m,
                                  input logic [REG_W-1:0] rd_m);
    logic hit_e, hit_m;
    hit_e = ld_e && v_e && (rd_e == addr);
    hit_m = ld_m && (rd_m == addr);
    return used && (addr != REG_W'(0)) && v_d && (hit_e || hit_m);
  endfunction

  always_comb begin
    rs1_sel_c = fwd_mux(ForwardA, rs1_data_D, alu_data_M, wb_data_W);
    rs2_sel_c = fwd_mux(ForwardB, rs2_data_D, alu_data_M, wb_data_W);
  end

  always_comb begin
    lu_rs1_c = lu_src(rs1_used_D, rs1_addr_D, valid_D, e_q.valid, e_q.mem_rden,
                      e_q.rd_addr, mem_rden_M, rd_addr_M);
    lu_rs2_c = lu_src(rs2_used_D, rs2_addr_D, valid_D, e_q.valid, e_q.mem_rden,
                      e_q.rd_addr, mem_rden_M, rd_addr_M);
    lu_c     = lu_rs1_c || lu_rs2_c;
  end

  // A flush redirects the front end, so it overrides any hold request.
  assign stall_D = valid_D && (lu_c || ex_busy) && !flush_E;
  assign stall_F = stall_D;

  // Decode bundle as it would enter EX, with forwarded operands.
  always_comb begin
    d_bundle_c          = '0;
    d_bundle_c.valid    = valid_D;
    d_bundle_c.pc       = pc_D;
    d_bundle_c.rs1_val  = rs1_sel_c;
    d_bundle_c.rs2_val  = rs2_sel_c;
    d_bundle_c.imm      = imm_D;
    d_bundle_c.rs1_addr = rs1_addr_D;
    d_bundle_c.rs2_addr = rs2_addr_D;
    d_bundle_c.rd_addr  = rd_addr_D;
    d_bundle_c.rd_wren  = rd_wren_D;
    d_bundle_c.mem_rden = mem_rden_D;
    d_bundle_c.mem_wren = mem_wren_D;
    d_bundle_c.br       = br_D;
    d_bundle_c.alu_op   = alu_op_D;
  end

  // Update priority: flush, busy hold, load-use bubble, normal advance.
  always_comb begin
    e_d   = e_q;
    cnt_d = cnt_q;
    if (flush_E) begin
      e_d = '0;
    end else if (ex_busy) begin
      e_d = e_q;
    end else if (lu_c) begin
      e_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      e_d = d_bundle_c;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_E    = e_q.valid;
  assign pc_E       = e_q.pc;
  assign rs1_val_E  = e_q.rs1_val;
  assign rs2_val_E  = e_q.rs2_val;
  assign imm_E      = e_q.imm;
  assign rs1_addr_E = e_q.rs1_addr;
  assign rs2_addr_E = e_q.rs2_addr;
  assign rd_addr_E  = e_q.rd_addr;
  assign rd_wren_E  = e_q.rd_wren;
  assign mem_rden_E = e_q.mem_rden;
  assign mem_wren_E = e_q.mem_wren;
  assign br_E       = e_q.br;
  assign alu_op_E   = e_q.alu_op;
  assign bubble_cnt = cnt_q;

endmodule
